example_mem_ctrl: RTL and testbench

- Parametrised memory-backed datapath block, the next generation of the `example` block (`clk`/`rst`/`en`/`din`/`dout`).
- Adds addressed storage, byte-enabled writes, configurable read latency, valid/ready handshakes on request and response, response buffering under backpressure, and out-of-range error reporting.
- Sits between a CPU load/store stage and local data memory in the CPU examples.

---
 rtl/example_mem_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_example_mem_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/example_mem_ctrl.sv
// -----------------------------------------------------------------------------
// example_mem_ctrl
//
// Memory-backed load/store datapath sitting between a CPU load/store stage and
// local data memory. Requests (read or byte-enabled write) are accepted with a
// valid/ready handshake. Reads travel a fixed-latency pipeline into a small
// response FIFO that is drained with a second valid/ready handshake. Credits
// for the FIFO are reserved when a read is accepted, so the FIFO cannot
// overflow no matter how long the consumer stalls.
//
// Ports:
//   clk        clock, everything on the rising edge
//   rst        asynchronous active-low reset (0 = reset)
//   en         block enable; 0 stops new acceptance only
//   req_valid  request present
//   req_ready  request can be accepted this cycle
//   req_we     1 = write, 0 = read
//   req_addr   word address
//   req_be     per-byte write enables
//   din        write data
//   rsp_valid  read response available (response FIFO not empty)
//   rsp_ready  consumer takes the head response
//   dout       head response data (holds last value when FIFO is empty)
//   rsp_err    head response came from an out-of-range read
// -----------------------------------------------------------------------------
module example_mem_ctrl #(
  parameter int bus_width  = 32,
  parameter int addr_width = 23,
  parameter int depth      = 256,
  parameter int rd_latency = 2,
  parameter int rsp_depth  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [addr_width-1:0]  req_addr,
  input  logic [bus_width/8-1:0] req_be,
  input  logic [bus_width-1:0]   din,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [bus_width-1:0]   dout,
  output logic                   rsp_err
);

  localparam int nbytes = bus_width / 8;
  localparam int idx_w  = (depth > 1) ? $clog2(depth) : 1;
  localparam int ptr_w  = (rsp_depth > 1) ? $clog2(rsp_depth) : 1;
  localparam int cnt_w  = $clog2(rsp_depth + 1);
  // The FIFO write itself is the last of the rd_latency stages, so only
  // rd_latency-1 pipeline registers sit between storage and the FIFO.
  localparam int pipe_n = rd_latency - 1;

  // One extra bit so that depth == 2**addr_width still compares correctly.
  localparam logic [addr_width:0] depth_lim = (addr_width + 1)'(depth);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic             in_range;
  logic [idx_w-1:0] idx;
  logic             accept;
  logic             rd_accept;
  logic             wr_accept;
  logic [cnt_w-1:0] outstanding_reg;
  logic [cnt_w-1:0] outstanding_next;

  assign in_range  = ({1'b0, req_addr} < depth_lim);
  assign idx       = req_addr[idx_w-1:0];
  // rst is folded in so that req_ready reads 0 for the whole reset interval,
  // not just after the first clock edge.
  assign req_ready = rst && en && (outstanding_reg < cnt_w'(rsp_depth));
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_we;
  // Out-of-range writes are accepted (they consume the handshake) but dropped.
  assign wr_accept = accept && req_we && in_range;

  // ---------------------------------------------------------------------------
  // Storage: byte-lane write, contents deliberately not reset
  // ---------------------------------------------------------------------------
  logic [bus_width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int i = 0; i < nbytes; i++) begin
        if (req_be[i]) begin
          mem[idx][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline -> FIFO write port (wb_*)
  // ---------------------------------------------------------------------------
  logic                 wb_valid;
  logic [bus_width-1:0] wb_data;
  logic                 wb_err;

  genvar gi;
  generate
    if (pipe_n == 0) begin : g_direct
      // Single-cycle latency: storage is sampled straight into the FIFO.
      assign wb_valid = rd_accept;
      assign wb_data  = in_range ? mem[idx] : '0;
      assign wb_err   = !in_range;
    end else begin : g_pipe
      for (gi = 0; gi < pipe_n; gi++) begin : g_stage
        logic                 valid_reg;
        logic                 err_reg;
        logic [bus_width-1:0] data_reg;

        if (gi == 0) begin : g_head
          // Registered storage read; data is sampled at the accept edge.
          always_ff @(posedge clk) begin
            data_reg <= mem[idx];
          end

          always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
              valid_reg <= 1'b0;
              err_reg   <= 1'b0;
            end else begin
              valid_reg <= rd_accept;
              err_reg   <= !in_range;
            end
          end
        end else begin : g_tail
          always_ff @(posedge clk) begin
            data_reg <= g_stage[gi-1].data_reg;
          end

          always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
              valid_reg <= 1'b0;
              err_reg   <= 1'b0;
            end else begin
              valid_reg <= g_stage[gi-1].valid_reg;
              err_reg   <= g_stage[gi-1].err_reg;
            end
          end
        end
      end

      // The storage index of an out-of-range read aliases a real word, so its
      // data is forced to zero here rather than trusted.
      assign wb_valid = g_stage[pipe_n-1].valid_reg;
      assign wb_err   = g_stage[pipe_n-1].err_reg;
      assign wb_data  = g_stage[pipe_n-1].err_reg ? '0 : g_stage[pipe_n-1].data_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  logic [bus_width-1:0] buf_data [rsp_depth];
  logic [rsp_depth-1:0] buf_err;

  logic [ptr_w-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [ptr_w-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [cnt_w-1:0]     count_reg, count_next;
  logic [cnt_w-1:0]     remain;
  logic                 push;
  logic                 pop;
  logic                 head_load;
  logic [bus_width-1:0] head_data_next;
  logic                 head_err_next;
  logic [bus_width-1:0] dout_reg;
  logic                 rsp_err_reg;

  // Pointers wrap modulo rsp_depth, which need not be a power of two.
  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(rsp_depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push      = wb_valid;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_valid = (count_reg != '0);
  assign dout      = dout_reg;
  assign rsp_err   = rsp_err_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr_reg] <= wb_data;
      buf_err[wr_ptr_reg]  <= wb_err;
    end
  end

  always_comb begin
    rd_ptr_next      = rd_ptr_reg;
    wr_ptr_next      = wr_ptr_reg;
    if (pop) begin
      rd_ptr_next = ptr_inc(rd_ptr_reg);
    end
    if (push) begin
      wr_ptr_next = ptr_inc(wr_ptr_reg);
    end
    count_next       = count_reg + cnt_w'(push) - cnt_w'(pop);
    outstanding_next = outstanding_reg + cnt_w'(rd_accept) - cnt_w'(pop);
    // Entries still held after this cycle's pop; if none, the new head is the
    // word being pushed right now and must bypass the storage array.
    remain           = count_reg - cnt_w'(pop);
    head_load        = (count_next != '0);
    if (remain == '0) begin
      head_data_next = wb_data;
      head_err_next  = wb_err;
    end else begin
      head_data_next = buf_data[rd_ptr_next];
      head_err_next  = buf_err[rd_ptr_next];
    end
  end

  // dout/rsp_err are registered copies of the head so that they keep the last
  // delivered response once the FIFO runs empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      outstanding_reg <= '0;
      dout_reg        <= '0;
      rsp_err_reg     <= 1'b0;
    end else begin
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
      if (head_load) begin
        dout_reg    <= head_data_next;
        rsp_err_reg <= head_err_next;
      end
    end
  end

endmodule

// File: tb/tb_example_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_example_mem_ctrl
//
// Directed bench for example_mem_ctrl: reset values, byte-enabled writes,
// read latency, backpressure and credit limit, out-of-range accesses,
// streaming with en toggling, and a mid-operation asynchronous reset.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_example_mem_ctrl;

  localparam int BW    = 32;
  localparam int AW    = 23;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int RSPD  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [3:0]    req_be;
  logic [BW-1:0] din;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [BW-1:0] dout;
  logic          rsp_err;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  example_mem_ctrl #(
    .bus_width (BW),
    .addr_width(AW),
    .depth     (DEPTH),
    .rd_latency(LAT),
    .rsp_depth (RSPD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_be   (req_be),
    .din      (din),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .dout     (dout),
    .rsp_err  (rsp_err)
  );

  // Fixed data pattern written to words 0..5.
  function automatic logic [31:0] pat(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] be, output logic acc);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    din       = d;
    req_be    = be;
    acc       = req_ready;
    tick;
    req_valid = 1'b0;
    req_we    = 1'b0;
    $display("[TB] write addr=%0d din=%h be=%b accepted=%0b", a, d, be, acc);
  endtask

  // Issues one read and returns what the response side shows one cycle
  // before and exactly LAT cycles after the accept; rsp_ready must be 1.
  task automatic do_read(input logic [AW-1:0] a, output logic acc, output logic early,
                         output logic valid, output logic [31:0] data, output logic err);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    req_be    = 4'b0000;
    acc       = req_ready;
    tick;
    req_valid = 1'b0;
    early     = rsp_valid;
    tick;
    valid     = rsp_valid;
    data      = dout;
    err       = rsp_err;
    tick;
    $display("[TB] read addr=%0d accepted=%0b valid=%0b dout=%h err=%0b", a, acc, valid, data, err);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en  = 1'b1;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      tests_run++;
      if (req_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_req_ready cyc%0d: got %b expected 0", i, req_ready);
      end
      tests_run++;
      if (rsp_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_rsp_valid cyc%0d: got %b expected 0", i, rsp_valid);
      end
      tests_run++;
      if (dout !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_dout cyc%0d: got %h expected 0", i, dout);
      end
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b expected 1", req_ready);
    end
    $display("[TB] reset released");
  endtask

  task automatic test_byte_write;
    logic acc, early, valid, err;
    logic [31:0] data;
    rsp_ready = 1'b1;
    do_write(23'd5, 32'hAABB_CCDD, 4'b1111, acc);
    tests_run++;
    if (acc !== 1'b1) begin
      tests_failed++;
      $display("FAIL bw_write1_accept: got %b expected 1", acc);
    end
    do_write(23'd5, 32'h1122_3344, 4'b0101, acc);
    tests_run++;
    if (acc !== 1'b1) begin
      tests_failed++;
      $display("FAIL bw_write2_accept: got %b expected 1", acc);
    end
    do_read(23'd5, acc, early, valid, data, err);
    tests_run++;
    if (acc !== 1'b1) begin
      tests_failed++;
      $display("FAIL bw_read_accept: got %b expected 1", acc);
    end
    tests_run++;
    if (early !== 1'b0) begin
      tests_failed++;
      $display("FAIL bw_early_valid: got %b expected 0", early);
    end
    tests_run++;
    if (valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL bw_latency_valid: got %b expected 1", valid);
    end
    tests_run++;
    if (data !== 32'hAA22_CC44) begin
      tests_failed++;
      $display("FAIL bw_dout: got %h expected aa22cc44", data);
    end
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL bw_err: got %b expected 0", err);
    end
  endtask

  task automatic test_backpressure;
    logic acc, early, valid, err, exp_ready;
    logic [31:0] data;
    rsp_ready = 1'b1;
    for (int a = 0; a < 6; a++) begin
      do_write(AW'(a), pat(a), 4'b1111, acc);
      tests_run++;
      if (acc !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_fill_accept a%0d: got %b expected 1", a, acc);
      end
    end
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = AW'(i);
      exp_ready = (i < 4);
      tests_run++;
      if (req_ready !== exp_ready) begin
        tests_failed++;
        $display("FAIL bp_ready rd%0d: got %b expected %b", i, req_ready, exp_ready);
      end
      $display("[TB] read addr=%0d offered ready=%0b", i, req_ready);
      tick;
    end
    req_valid = 1'b0;
    tick;
    tests_run++;
    if (rsp_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_full_valid: got %b expected 1", rsp_valid);
    end
    tests_run++;
    if (req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_full_ready: got %b expected 0", req_ready);
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (rsp_valid !== 1'b1 || dout !== pat(k)) begin
        tests_failed++;
        $display("FAIL bp_drain rsp%0d: got valid=%b dout=%h expected valid=1 dout=%h",
                 k, rsp_valid, dout, pat(k));
      end
      $display("[TB] response %0d dout=%h", k, dout);
      tick;
      if (k == 0) begin
        tests_run++;
        if (req_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL bp_ready_return: got %b expected 1", req_ready);
        end
      end
    end
    tests_run++;
    if (rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_empty: got %b expected 0", rsp_valid);
    end
    for (int a = 4; a < 6; a++) begin
      do_read(AW'(a), acc, early, valid, data, err);
      tests_run++;
      if (acc !== 1'b1 || valid !== 1'b1 || data !== pat(a) || err !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_late_read a%0d: got acc=%b valid=%b dout=%h err=%b expected 1 1 %h 0",
                 a, acc, valid, data, err, pat(a));
      end
    end
  endtask

  task automatic test_out_of_range;
    logic acc, early, valid, err;
    logic [31:0] data;
    rsp_ready = 1'b1;
    do_write(23'd44, 32'h4444_4444, 4'b1111, acc);
    do_write(23'd300, 32'hFFFF_FFFF, 4'b1111, acc);
    tests_run++;
    if (acc !== 1'b1) begin
      tests_failed++;
      $display("FAIL oor_write_accept: got %b expected 1", acc);
    end
    do_read(23'd44, acc, early, valid, data, err);
    tests_run++;
    if (valid !== 1'b1 || data !== 32'h4444_4444 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL oor_alias_unchanged: got valid=%b dout=%h err=%b expected 1 44444444 0",
               valid, data, err);
    end
    do_read(23'd300, acc, early, valid, data, err);
    tests_run++;
    if (valid !== 1'b1 || data !== 32'h0 || err !== 1'b1) begin
      tests_failed++;
      $display("FAIL oor_read: got valid=%b dout=%h err=%b expected 1 00000000 1",
               valid, data, err);
    end
  endtask

  // Ten reads of words 0..5 (cycling); en is low at cycles off_t and off_t+1.
  // Each accepted read must show up exactly LAT cycles later.
  task automatic run_stream(input int off_t, input string tag);
    int          due_q[$];
    logic [31:0] dat_q[$];
    int          accepted;
    logic        exp_valid;
    accepted  = 0;
    rsp_ready = 1'b1;
    for (int t = 0; t < 16; t++) begin
      en        = !(t == off_t || t == off_t + 1);
      req_valid = (accepted < 10);
      req_we    = 1'b0;
      req_addr  = AW'(accepted % 6);
      #1;
      if (req_valid) begin
        tests_run++;
        if (req_ready !== en) begin
          tests_failed++;
          $display("FAIL %s_ready t%0d: got %b expected %b", tag, t, req_ready, en);
        end
      end
      exp_valid = (due_q.size() > 0) && (due_q[0] == t);
      tests_run++;
      if (rsp_valid !== exp_valid) begin
        tests_failed++;
        $display("FAIL %s_valid t%0d: got %b expected %b", tag, t, rsp_valid, exp_valid);
      end
      if (exp_valid) begin
        tests_run++;
        if (dout !== dat_q[0]) begin
          tests_failed++;
          $display("FAIL %s_dout t%0d: got %h expected %h", tag, t, dout, dat_q[0]);
        end
        $display("[TB] %s t=%0d response dout=%h", tag, t, dout);
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
      end
      if (req_valid && en) begin
        due_q.push_back(t + LAT);
        dat_q.push_back(pat(accepted % 6));
        accepted++;
      end
      tick;
    end
    en        = 1'b1;
    req_valid = 1'b0;
  endtask

  task automatic test_streaming;
    run_stream(-10, "stream");
    run_stream(4, "stream_en");
  endtask

  task automatic test_mid_reset;
    logic acc, early, valid, err;
    logic [31:0] data;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = AW'(i);
      tick;
    end
    req_valid = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL mrst_pre_valid: got %b expected 1", rsp_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    $display("[TB] reset asserted mid-operation");
    tests_run++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || dout !== 32'h0) begin
      tests_failed++;
      $display("FAIL mrst_async: got valid=%b ready=%b dout=%h expected 0 0 00000000",
               rsp_valid, req_ready, dout);
    end
    tick;
    tick;
    rst       = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      tests_run++;
      if (rsp_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL mrst_stale cyc%0d: got %b expected 0", i, rsp_valid);
      end
    end
    do_read(23'd3, acc, early, valid, data, err);
    tests_run++;
    if (acc !== 1'b1 || valid !== 1'b1 || data !== pat(3) || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL mrst_storage_kept: got acc=%b valid=%b dout=%h err=%b expected 1 1 %h 0",
               acc, valid, data, err, pat(3));
    end
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_be    = 4'b0000;
    din       = 32'h0;
    rsp_ready = 1'b0;
    test_reset;
    test_byte_write;
    test_backpressure;
    test_out_of_range;
    test_streaming;
    test_mid_reset;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
